// File: rtl/xmit_pkg.sv
// Shared types and helpers for the transmit traffic generator: FSM state
// encoding, control-block packing and the payload LFSR polynomial taps.
package xmit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LO_FRAME = 2'd1,
    HI_FRAME = 2'd2,
    DONE     = 2'd3
  } xmit_state_e;

  // Left-shifting Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

  // Control block is the frame length repeated in both halves; the caller
  // truncates the result to 2*len_w bits.
  function automatic logic [63:0] pack_ctrl(input logic [31:0] len, input int len_w);
    return ({32'd0, len} << len_w) | {32'd0, len};
  endfunction

endpackage

// File: rtl/xmit_tgen_lfsr.sv
// Payload PRBS generator for the traffic generator; only built when
// XMIT_TGEN_PRBS_EN is defined.
`ifdef XMIT_TGEN_PRBS_EN
module xmit_tgen_lfsr
  import xmit_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] seed_fix;

  // An all-zero register would lock up, so a zero seed starts at 01
  assign seed_fix = (seed == 8'd0) ? LFSR_ZERO_SEED : seed;
  assign value    = load ? seed_fix : lfsr_q;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_ZERO_SEED;
    end else if (step) begin
      lfsr_q <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule
`endif

// File: rtl/xmit_traffic_gen.sv
// Transmit traffic generator: loops of cfg_num_lo lo-priority frames followed
// by one hi-priority frame. Define XMIT_TGEN_PRBS_EN for an LFSR payload.
module xmit_traffic_gen
  import xmit_pkg::*;
#(
  parameter int LEN_W  = 12,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_W-1:0]     cfg_len_lo,
  input  logic [LEN_W-1:0]     cfg_len_hi,
  input  logic [CNT_W-1:0]     cfg_num_lo,
  input  logic [CNT_W-1:0]     cfg_num_loops,
  input  logic [DATA_W-1:0]    cfg_seed_lo,
  input  logic [DATA_W-1:0]    cfg_seed_hi,
  input  logic                 f_ready,
  output logic [DATA_W-1:0]    f_data_in,
  output logic [2*LEN_W-1:0]   f_ctrl_in,
  output logic                 f_rec_data_valid,
  output logic                 f_rec_frame_valid,
  output logic                 f_hi_priority,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     frame_cnt
);

  xmit_state_e        state_q, state_d;
  logic [LEN_W-1:0]   len_lo_q, len_hi_q, beat_q, cur_len;
  logic [CNT_W-1:0]   num_lo_q, num_loops_q, lo_sent_q, loop_q, frame_cnt_q;
  logic [DATA_W-1:0]  seed_lo_q, seed_hi_q, seed_cur, payload;
  logic               stop_q, in_frame, xfer, last_xfer, stop_pend, loop_end;

  assign in_frame  = (state_q == LO_FRAME) || (state_q == HI_FRAME);
  assign cur_len   = (state_q == HI_FRAME) ? len_hi_q : len_lo_q;
  assign seed_cur  = (state_q == HI_FRAME) ? seed_hi_q : seed_lo_q;
  assign xfer      = in_frame && f_ready;
  assign last_xfer = xfer && (beat_q == cur_len - LEN_W'(1));
  // A stop arriving on the final beat still ends the run after this frame
  assign stop_pend = stop_q || stop;
  assign loop_end  = (num_loops_q != '0) && (loop_q + CNT_W'(1) == num_loops_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (cfg_num_lo != '0) ? LO_FRAME : HI_FRAME;
      end
      LO_FRAME: begin
        if (last_xfer) begin
          if (stop_pend)                          state_d = DONE;
          else if (lo_sent_q + CNT_W'(1) < num_lo_q) state_d = LO_FRAME;
          else                                    state_d = HI_FRAME;
        end
      end
      HI_FRAME: begin
        if (last_xfer) begin
          if (stop_pend || loop_end) state_d = DONE;
          else if (num_lo_q != '0)   state_d = LO_FRAME;
          else                       state_d = HI_FRAME;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_lo_q    <= '0;
      len_hi_q    <= '0;
      num_lo_q    <= '0;
      num_loops_q <= '0;
      seed_lo_q   <= '0;
      seed_hi_q   <= '0;
      beat_q      <= '0;
      lo_sent_q   <= '0;
      loop_q      <= '0;
      frame_cnt_q <= '0;
      stop_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        // Configuration is frozen here for the whole run; zero length means one beat
        len_lo_q    <= (cfg_len_lo == '0) ? LEN_W'(1) : cfg_len_lo;
        len_hi_q    <= (cfg_len_hi == '0) ? LEN_W'(1) : cfg_len_hi;
        num_lo_q    <= cfg_num_lo;
        num_loops_q <= cfg_num_loops;
        seed_lo_q   <= cfg_seed_lo;
        seed_hi_q   <= cfg_seed_hi;
        beat_q      <= '0;
        lo_sent_q   <= '0;
        loop_q      <= '0;
        frame_cnt_q <= '0;
        stop_q      <= stop;
      end else if (in_frame) begin
        if (stop) stop_q <= 1'b1;
        if (last_xfer) begin
          beat_q      <= '0;
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          if (state_q == LO_FRAME) begin
            seed_lo_q <= seed_lo_q + DATA_W'(1);
            lo_sent_q <= lo_sent_q + CNT_W'(1);
          end else begin
            seed_hi_q <= seed_hi_q + DATA_W'(1);
            lo_sent_q <= '0;
            loop_q    <= loop_q + CNT_W'(1);
          end
        end else if (xfer) begin
          beat_q <= beat_q + LEN_W'(1);
        end
      end else if (state_q == DONE) begin
        stop_q <= 1'b0;
      end
    end
  end

`ifdef XMIT_TGEN_PRBS_EN
  logic [7:0] prbs;

  xmit_tgen_lfsr u_lfsr (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (f_rec_frame_valid),
    .step    (xfer),
    .seed    (8'(seed_cur)),
    .value   (prbs)
  );

  assign payload = DATA_W'(prbs);
`else
  assign payload = seed_cur;
`endif

  // All outputs decode from registered state, so a stall freezes them
  assign f_rec_data_valid  = in_frame;
  assign f_rec_frame_valid = in_frame && (beat_q == '0);
  assign f_ctrl_in         = f_rec_frame_valid ? (2*LEN_W)'(pack_ctrl(32'(cur_len), LEN_W)) : '0;
  assign f_data_in         = in_frame ? payload : '0;
  assign f_hi_priority     = (state_q == HI_FRAME);
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign frame_cnt         = frame_cnt_q;

endmodule

// File: tb/tb_xmit_traffic_gen.sv
// Bench for xmit_traffic_gen: table-driven runs and randomized runs checked
// beat-by-beat against a frame-list model, plus reset corner sequences.
module tb_xmit_traffic_gen;

  localparam int LEN_W  = 12;
  localparam int CNT_W  = 16;
  localparam int DATA_W = 8;

  logic                clk_sys = 1'b0;
  logic                rst_n   = 1'b1;
  logic                start   = 1'b0;
  logic                stop    = 1'b0;
  logic                f_ready = 1'b0;
  logic [LEN_W-1:0]    cfg_len_lo = '0, cfg_len_hi = '0;
  logic [CNT_W-1:0]    cfg_num_lo = '0, cfg_num_loops = '0;
  logic [DATA_W-1:0]   cfg_seed_lo = '0, cfg_seed_hi = '0;
  logic [DATA_W-1:0]   f_data_in;
  logic [2*LEN_W-1:0]  f_ctrl_in;
  logic                f_rec_data_valid, f_rec_frame_valid, f_hi_priority, busy, done;
  logic [CNT_W-1:0]    frame_cnt;

  xmit_traffic_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk_sys           (clk_sys),
    .reset             (rst_n),
    .start             (start),
    .stop              (stop),
    .cfg_len_lo        (cfg_len_lo),
    .cfg_len_hi        (cfg_len_hi),
    .cfg_num_lo        (cfg_num_lo),
    .cfg_num_loops     (cfg_num_loops),
    .cfg_seed_lo       (cfg_seed_lo),
    .cfg_seed_hi       (cfg_seed_hi),
    .f_ready           (f_ready),
    .f_data_in         (f_data_in),
    .f_ctrl_in         (f_ctrl_in),
    .f_rec_data_valid  (f_rec_data_valid),
    .f_rec_frame_valid (f_rec_frame_valid),
    .f_hi_priority     (f_hi_priority),
    .busy              (busy),
    .done              (done),
    .frame_cnt         (frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic               fv;
    logic [2*LEN_W-1:0] ctrl;
    logic [DATA_W-1:0]  data;
    logic               hi;
  } beat_t;

  typedef struct {
    string nm;
    int    len_lo, len_hi, num_lo, loops, seed_lo, seed_hi;
    int    ready_mode, stop_beat, exp_frames, exp_beats;
  } vec_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [63:0] all_outs();
    return {11'd0, f_data_in, f_ctrl_in, f_rec_data_valid, f_rec_frame_valid,
            f_hi_priority, busy, done, frame_cnt};
  endfunction

  // Expected beat list: each loop is num_lo lo frames then one hi frame; a stop
  // seen on beat k ends the run after the frame that contains beat k.
  task automatic build_stream(input int len_lo, input int len_hi, input int num_lo,
                              input int loops, input int seed_lo, input int seed_hi,
                              input int stop_beat, output int n_frames);
    int ll, lh, sl, sh, beats, loop, len, seed;
    bit fin, hi;
    beat_t b;
    logic [7:0] v;
    ll = (len_lo == 0) ? 1 : len_lo;
    lh = (len_hi == 0) ? 1 : len_hi;
    sl = seed_lo; sh = seed_hi; beats = 0; loop = 0; fin = 0;
    exp_q.delete();
    n_frames = 0;
    while (!fin && n_frames < 5000) begin
      for (int f = 0; f <= num_lo && !fin; f++) begin
        hi   = (f == num_lo);
        len  = hi ? lh : ll;
        seed = hi ? sh : sl;
        v    = (seed == 0) ? 8'h01 : 8'(seed);
        for (int k = 0; k < len; k++) begin
          b.fv   = (k == 0);
          b.ctrl = (k == 0) ? {LEN_W'(len), LEN_W'(len)} : '0;
`ifdef XMIT_TGEN_PRBS_EN
          b.data = DATA_W'(v);
          v      = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
          b.data = DATA_W'(seed);
`endif
          b.hi   = hi;
          exp_q.push_back(b);
        end
        n_frames++;
        if (stop_beat >= 0 && stop_beat < beats + len) fin = 1;
        beats += len;
        if (hi) sh = (sh + 1) % 256;
        else    sl = (sl + 1) % 256;
      end
      loop++;
      if (loops != 0 && loop == loops) fin = 1;
    end
  endtask

  task automatic run_case(input vec_t v);
    int n_frames, beats, cyc, want_frames, want_beats;
    bit got_done, stop_sent, prev_stall;
    logic [35:0] snap, cur;
    beat_t e;
    build_stream(v.len_lo, v.len_hi, v.num_lo, v.loops, v.seed_lo, v.seed_hi,
                 v.stop_beat, n_frames);
    want_frames = (v.exp_frames >= 0) ? v.exp_frames : n_frames;
    want_beats  = (v.exp_beats  >= 0) ? v.exp_beats  : exp_q.size();
    beats = 0; cyc = 0; got_done = 0; prev_stall = 0; snap = '0;
    @(negedge clk_sys);
    cfg_len_lo    = LEN_W'(v.len_lo);
    cfg_len_hi    = LEN_W'(v.len_hi);
    cfg_num_lo    = CNT_W'(v.num_lo);
    cfg_num_loops = CNT_W'(v.loops);
    cfg_seed_lo   = DATA_W'(v.seed_lo);
    cfg_seed_hi   = DATA_W'(v.seed_hi);
    start     = 1'b1;
    stop      = (v.stop_beat == 0);
    stop_sent = (v.stop_beat == 0);
    @(negedge clk_sys);
    // Configuration changes during the run must have no effect
    cfg_len_lo    = LEN_W'($urandom);
    cfg_len_hi    = LEN_W'($urandom);
    cfg_num_lo    = CNT_W'($urandom);
    cfg_num_loops = CNT_W'($urandom);
    cfg_seed_lo   = DATA_W'($urandom);
    cfg_seed_hi   = DATA_W'($urandom);
    while (cyc < 20000) begin
      start = 1'b0;
      stop  = 1'b0;
      case (v.ready_mode)
        0:       f_ready = 1'b1;
        1:       f_ready = cyc[0];
        default: f_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (done) begin
        got_done = 1;
        break;
      end
      cur = {f_rec_data_valid, f_rec_frame_valid, f_ctrl_in, f_data_in, f_hi_priority};
      if (prev_stall) check({v.nm, ".stall_hold"}, 64'(cur), 64'(snap));
      check({v.nm, ".valid_busy"}, {62'd0, f_rec_data_valid, busy}, 64'h3);
      if (f_rec_data_valid) begin
        if (exp_q.size() == 0) begin
          check({v.nm, ".extra_beat"}, 64'(beats), 64'(want_beats));
        end else begin
          e = exp_q[0];
          check($sformatf("%s.beat%0d", v.nm, beats),
                64'({f_rec_frame_valid, f_ctrl_in, f_data_in, f_hi_priority}),
                64'({e.fv, e.ctrl, e.data, e.hi}));
        end
        if (!stop_sent && v.stop_beat > 0 && beats == v.stop_beat) begin
          stop      = 1'b1;
          stop_sent = 1;
        end
        if (f_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          beats++;
        end
      end
      prev_stall = f_rec_data_valid && !f_ready;
      snap       = cur;
      start      = ($urandom_range(0, 7) == 0);
      @(negedge clk_sys);
      cyc++;
    end
    start = 1'b0;
    stop  = 1'b0;
    check({v.nm, ".done_seen"}, 64'(got_done), 64'd1);
    check({v.nm, ".frame_cnt"}, 64'(frame_cnt), 64'(want_frames));
    check({v.nm, ".beats"}, 64'(beats), 64'(want_beats));
    check({v.nm, ".left_over"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk_sys);
    check({v.nm, ".done_pulse_busy"}, {62'd0, done, busy}, 64'd0);
    check({v.nm, ".frame_cnt_hold"}, 64'(frame_cnt), 64'(want_frames));
  endtask

  vec_t tbl[9];
  vec_t rv;
  bit   saw;

  initial begin
    tbl[0] = '{"lohi",      64, 512, 10, 2,   0, 240, 0,  -1, 22, 2304};
    tbl[1] = '{"toggle",    64, 512, 10, 2,   0, 240, 1,  -1, 22, 2304};
    tbl[2] = '{"stop3",     64, 512, 10, 0,   0, 240, 0, 133,  3,  192};
    tbl[3] = '{"hi_len0",   64,   0,  0, 3,   9,   7, 0,  -1,  3,    3};
    tbl[4] = '{"startstop",  7,   9,  2, 1,  12,  34, 0,   0,  1,    7};
    tbl[5] = '{"seedwrap",   3,   2,  2, 1, 255, 254, 2,  -1,  3,    8};
    tbl[6] = '{"lo_len0",    0,   1,  3, 2,  50,  60, 2,  -1,  8,    8};
    tbl[7] = '{"stop_rand",  5,   3,  2, 0,  10, 200, 2,  20,  5,   23};
    tbl[8] = '{"seed01",     4,   4,  1, 1,   1,   0, 2,  -1,  2,    8};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("idle_outputs", all_outs(), 64'd0);

    for (int i = 0; i < 9; i++) run_case(tbl[i]);

    for (int r = 0; r < 10; r++) begin
      rv.nm         = $sformatf("rand%0d", r);
      rv.len_lo     = $urandom_range(0, 6);
      rv.len_hi     = $urandom_range(0, 6);
      rv.num_lo     = $urandom_range(0, 3);
      rv.loops      = $urandom_range(1, 3);
      rv.seed_lo    = $urandom_range(0, 255);
      rv.seed_hi    = $urandom_range(0, 255);
      rv.ready_mode = 2;
      rv.stop_beat  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 12);
      rv.exp_frames = -1;
      rv.exp_beats  = -1;
      run_case(rv);
    end

    // Reset in the middle of a frame aborts at once and never pulses done
    @(negedge clk_sys);
    cfg_len_lo = 12'd64; cfg_len_hi = 12'd64; cfg_num_lo = 16'd2; cfg_num_loops = 16'd1;
    cfg_seed_lo = 8'h11; cfg_seed_hi = 8'h22;
    start = 1'b1; f_ready = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("midrst_active", {63'd0, f_rec_data_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_async", all_outs(), 64'd0);
    @(posedge clk_sys);
    #1;
    check("midrst_edge", all_outs(), 64'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    saw = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (done || busy) saw = 1;
    end
    check("midrst_no_done", 64'(saw), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
